vram_write_arbiter: RTL

VRAM_WRITE_ARBITER -- requirements
Module: vram_write_arbiter

---
 rtl/vram_write_arbiter.sv | 102 ++++++++++
 1 files changed

// File: rtl/vram_write_arbiter.sv
// Two-source VRAM write arbiter: frame-copy stream has priority, brush writes
// are buffered in a small FIFO and forced through after STARVE_LIMIT waits.
module vram_write_arbiter #(
  parameter int ACTIVE_COLUMNS = 640,
  parameter int ACTIVE_ROWS    = 480,
  parameter int ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS),
  parameter int DATA_WIDTH     = 1,
  parameter int FIFO_DEPTH     = 4,
  parameter int STARVE_LIMIT   = 16
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          copy_valid_i,
  input  logic [ADDR_WIDTH-1:0]         copy_address_i,
  input  logic [DATA_WIDTH-1:0]         copy_data_i,
  output logic                          copy_ready_o,
  input  logic                          brush_valid_i,
  input  logic [ADDR_WIDTH-1:0]         brush_address_i,
  input  logic [DATA_WIDTH-1:0]         brush_data_i,
  output logic                          brush_ready_o,
  output logic [ADDR_WIDTH-1:0]         vram_write_address_o,
  output logic [DATA_WIDTH-1:0]         vram_write_data_o,
  output logic                          vram_write_ena_o,
  output logic                          brush_drop_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDR_WIDTH:0] CELLS   = (ADDR_WIDTH+1)'(ACTIVE_COLUMNS*ACTIVE_ROWS);
  localparam logic [CW-1:0]       DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0]       LIMIT_C = SW'(STARVE_LIMIT);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wr_req_t;

  wr_req_t         mem [FIFO_DEPTH];
  wr_req_t         gnt_req, wr_q;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [SW-1:0]   starve_cnt;
  logic            fifo_empty, force_brush, copy_gnt, brush_gnt, gnt;
  logic            brush_hs, in_range, push, wr_ena_q, drop_q;

  assign fifo_empty    = (count == '0);
  assign force_brush   = (starve_cnt == LIMIT_C) && !fifo_empty;
  assign copy_ready_o  = !force_brush;
  assign brush_ready_o = (count < DEPTH_C);

  assign copy_gnt  = copy_valid_i && copy_ready_o;
  assign brush_gnt = !copy_gnt && !fifo_empty;
  assign gnt       = copy_gnt || brush_gnt;
  assign gnt_req   = copy_gnt ? {copy_address_i, copy_data_i} : mem[rd_ptr];

  // Out-of-range brush requests still handshake, they are just never stored.
  assign brush_hs = brush_valid_i && brush_ready_o;
  assign in_range = ({1'b0, brush_address_i} < CELLS);
  assign push     = brush_hs && in_range;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= {brush_address_i, brush_data_i};
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else begin
      if (push)      wr_ptr <= wr_ptr + PW'(1);
      if (brush_gnt) rd_ptr <= rd_ptr + PW'(1);
      if (push && !brush_gnt)      count <= count + CW'(1);
      else if (!push && brush_gnt) count <= count - CW'(1);
      if (brush_gnt || fifo_empty)
        starve_cnt <= '0;
      else if (copy_gnt && starve_cnt != LIMIT_C)
        starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // Write port register: data only moves on a grant so it holds when idle.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ena_q <= 1'b0;
      wr_q     <= '0;
      drop_q   <= 1'b0;
    end else begin
      wr_ena_q <= gnt;
      if (gnt) wr_q <= gnt_req;
      drop_q   <= brush_hs && !in_range;
    end
  end

  assign vram_write_ena_o     = wr_ena_q;
  assign vram_write_address_o = wr_q.addr;
  assign vram_write_data_o    = wr_q.data;
  assign brush_drop_o         = drop_q;
  assign fifo_count_o         = count;
endmodule
